// File: rtl/vga_pixel_pipe.sv
// Pixel-fetch and colour stage behind the VGA scanner: 4x-scaled framebuffer
// addressing, blinking inverted cursor cell, RGB444 out with aligned syncs.
module vga_pixel_pipe #(
  parameter int FB_W         = 160,
  parameter int FB_H         = 120,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        en,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [14:0] fb_addr,
  input  logic [11:0] fb_data,
  input  logic        cursor_en,
  input  logic [7:0]  cursor_x,
  input  logic [6:0]  cursor_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam logic [7:0] L_FB_W       = 8'(FB_W);
  localparam logic [6:0] L_FB_H       = 7'(FB_H);
  localparam logic [7:0] L_BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0]  w_cx;
  logic [6:0]  w_cy;
  logic [14:0] w_addr;
  logic        w_tick;
  logic        w_hit;
  logic [11:0] w_rgb;
  logic        w_unused;

  logic        r_vs_q;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_en1;
  logic        r_hit1;
  logic        r_cur_en;
  logic [7:0]  r_cur_x;
  logic [6:0]  r_cur_y;
  logic [7:0]  r_blink_cnt;
  logic        r_cursor_on;

  assign w_cx     = x[9:2];
  assign w_cy     = y[8:2];
  // cy*160 split as cy*128 + cy*32 so no multiplier is needed
  assign w_addr   = ({8'd0, w_cy} << 7) + ({8'd0, w_cy} << 5) + {7'd0, w_cx};
  assign w_tick   = r_vs_q & ~vs;
  assign w_hit    = r_cur_en && (w_cx == r_cur_x) && (w_cy == r_cur_y) &&
                    (r_cur_x < L_FB_W) && (r_cur_y < L_FB_H);
  assign w_unused = ^{x[15:10], x[1:0], y[15:9], y[1:0]};

  always_comb begin
    w_rgb = fb_data;
    if (r_hit1 && r_cursor_on) begin
      w_rgb = fb_data ^ 12'hFFF;
    end else begin
      w_rgb = fb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr <= 15'd0;
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_en1   <= 1'b0;
      r_hit1  <= 1'b0;
    end else begin
      fb_addr <= w_addr;
      r_hs1   <= hs;
      r_vs1   <= vs;
      r_en1   <= en;
      r_hit1  <= w_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
    end else begin
      if (r_en1) begin
        {vga_r, vga_g, vga_b} <= w_rgb;
      end else begin
        {vga_r, vga_g, vga_b} <= 12'h000;
      end
      vga_hs <= r_hs1;
      vga_vs <= r_vs1;
    end
  end

  // Cursor shadow and blink only move at the start of vsync, while en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_q      <= 1'b1;
      r_cur_en    <= 1'b0;
      r_cur_x     <= 8'd0;
      r_cur_y     <= 7'd0;
      r_blink_cnt <= 8'd0;
      r_cursor_on <= 1'b1;
    end else begin
      r_vs_q <= vs;
      if (w_tick) begin
        r_cur_en <= cursor_en;
        r_cur_x  <= cursor_x;
        r_cur_y  <= cursor_y;
        if (r_blink_cnt == L_BLINK_LAST) begin
          r_blink_cnt <= 8'd0;
          r_cursor_on <= ~r_cursor_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: vector table, cursor/blink/reset
// sequences and a randomized run against a frame-level reference model.
module tb_vga_pixel_pipe;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, en = 1'b0;
  logic [15:0] x = 16'd0, y = 16'd0;
  logic [11:0] fb_data = 12'h000;
  logic        cursor_en = 1'b0;
  logic [7:0]  cursor_x = 8'd0;
  logic [6:0]  cursor_y = 7'd0;
  logic [14:0] fb_addr;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          ticks;
  logic        sh_en;
  int          sh_x, sh_y;
  logic        p_vs;
  logic        s1_hs, s1_vs, s1_en, s1_hit;
  logic [14:0] e_addr;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs;

  typedef struct {
    logic        en;
    logic [15:0] x, y;
    logic        hs, vs;
    logic [11:0] fb;
    logic [14:0] a;
    logic [11:0] rgb;
    logic        ehs, evs;
  } vec_t;
  vec_t tbl[7];

  vga_pixel_pipe #(.FB_W(160), .FB_H(120), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .en(en), .x(x), .y(y),
    .fb_addr(fb_addr), .fb_data(fb_data), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ticks = 0; sh_en = 1'b0; sh_x = 0; sh_y = 0; p_vs = 1'b1;
    s1_hs = 1'b1; s1_vs = 1'b1; s1_en = 1'b0; s1_hit = 1'b0;
    e_addr = 15'd0; e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
  endtask

  // Frame-level view: cursor visible in even blink half-periods, shadow = last tick's inputs
  task automatic model_edge();
    int  cx, cy;
    bit  on;
    cx = (int'(x) / 4) % 256;
    cy = (int'(y) / 4) % 128;
    on = ((ticks / BF) % 2) == 0;
    if (s1_en) e_rgb = (s1_hit && on) ? (fb_data ^ 12'hFFF) : fb_data;
    else       e_rgb = 12'h000;
    e_hs   = s1_hs;
    e_vs   = s1_vs;
    e_addr = 15'((cy * 160 + cx) % 32768);
    s1_hit = sh_en && (cx == sh_x) && (cy == sh_y) && (sh_x < 160) && (sh_y < 120);
    s1_hs  = hs; s1_vs = vs; s1_en = en;
    if (p_vs && !vs) begin
      ticks++;
      sh_en = cursor_en; sh_x = int'(cursor_x); sh_y = int'(cursor_y);
    end
    p_vs = vs;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk("addr", {17'd0, fb_addr}, {17'd0, e_addr});
    chk("pix", {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, e_rgb, e_hs, e_vs});
  endtask

  task automatic tick_frame(input int low_cycles);
    en = 1'b0; x = 16'd0; y = 16'd0; vs = 1'b1;
    cyc();
    vs = 1'b0;
    repeat (low_cycles) cyc();
    vs = 1'b1;
    cyc();
  endtask

  task automatic pix(input string nm, input int px, input int py,
                     input logic [11:0] fb, input logic [11:0] exp);
    en = 1'b1; hs = 1'b1; vs = 1'b1; x = 16'(px); y = 16'(py);
    cyc();
    fb_data = fb;
    cyc();
    chk(nm, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'd5,   16'd9,   1'b0, 1'b1, 12'hABC, 15'd321,   12'hABC, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'd639, 16'd479, 1'b1, 1'b1, 12'h5A5, 15'd19199, 12'h5A5, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 16'd0,   16'd0,   1'b1, 1'b1, 12'hFFF, 15'd0,     12'h000, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'd8,   16'd4,   1'b1, 1'b1, 12'h0F0, 15'd162,   12'h0F0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 16'd100, 16'd200, 1'b1, 1'b1, 12'h123, 15'd8025,  12'h123, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'd0,   16'd0,   1'b0, 1'b0, 12'hFFF, 15'd0,     12'h000, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'd4,   16'd0,   1'b0, 1'b1, 12'hABC, 15'd1,     12'hABC, 1'b0, 1'b1};

    model_reset();
    cyc();
    cyc();
    #2 rst = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en; x = tbl[i].x; y = tbl[i].y; hs = tbl[i].hs; vs = tbl[i].vs;
      cyc();
      chk("vec_addr", {17'd0, fb_addr}, {17'd0, tbl[i].a});
      fb_data = tbl[i].fb;
      cyc();
      chk("vec_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, tbl[i].rgb});
      chk("vec_sync", {30'd0, vga_hs, vga_vs}, {30'd0, tbl[i].ehs, tbl[i].evs});
    end

    // asynchronous reset between edges while vga_r shows 4'hA and vga_hs is low
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_async_sync", {30'd0, vga_hs, vga_vs}, 32'd3);
    chk("rst_async_addr", {17'd0, fb_addr}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    hs = 1'b1; vs = 1'b1; en = 1'b0; x = 16'd0; y = 16'd0;
    cyc();
    cyc();

    // cursor overlay, then blink with BLINK_FRAMES=2
    cursor_en = 1'b1; cursor_x = 8'd1; cursor_y = 7'd2;
    tick_frame(1);
    pix("cur_4_8", 4, 8, 12'h123, 12'hEDC);
    pix("cur_7_11", 7, 11, 12'h123, 12'hEDC);
    pix("cur_5_10", 5, 10, 12'h123, 12'hEDC);
    pix("cur_x8", 8, 8, 12'h123, 12'h123);
    pix("cur_y12", 4, 12, 12'h123, 12'h123);
    tick_frame(1);
    pix("blink_off", 4, 8, 12'h123, 12'h123);
    tick_frame(50);
    pix("blink_long_vs", 6, 9, 12'h123, 12'h123);
    tick_frame(1);
    pix("blink_on", 4, 8, 12'h123, 12'hEDC);

    // out-of-range cursor coordinates never match
    cursor_x = 8'd160; cursor_y = 7'd2;
    tick_frame(1);
    pix("oor_x_636", 636, 8, 12'h123, 12'h123);
    pix("oor_x_640", 640, 8, 12'h123, 12'h123);
    pix("oor_x_4", 4, 8, 12'h123, 12'h123);
    cursor_x = 8'd1; cursor_y = 7'd120;
    tick_frame(1);
    pix("oor_y_480", 4, 480, 12'h456, 12'h456);
    pix("oor_y_476", 4, 476, 12'h456, 12'h456);

    // randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) vs = ~vs;
      if ($urandom_range(0, 7) == 0) hs = ~hs;
      en = vs && ($urandom_range(0, 3) != 0);
      x  = en ? 16'($urandom_range(0, 63)) : 16'd0;
      y  = en ? 16'($urandom_range(0, 63)) : 16'd0;
      fb_data   = 12'($urandom_range(0, 4095));
      cursor_en = ($urandom_range(0, 3) != 0);
      cursor_x  = 8'($urandom_range(0, 15));
      cursor_y  = 7'($urandom_range(0, 15));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Pixel-fetch and colour stage placed directly downstream of the VGA timing scanner. It consumes the scanner's `hs`, `vs`, `en`, `x` and `y` and converts each visible pixel into a framebuffer read address. A 160x120 framebuffer is scaled 4x to fill 640x480. The block captures the synchronous-RAM read data, overlays a blinking inverted cursor cell, and drives RGB444 with sync pulses delayed to stay aligned with the pixel data.

## Interface
Parameters:
- `FB_W`, 160, framebuffer width in cells (the 640-pixel line divided by 4).
- `FB_H`, 120, framebuffer height in cells (the 480-line frame divided by 4).
- `BLINK_FRAMES`, 30, number of frames per cursor blink half-period (valid range 1..255).

Ports:
- `clk`  in  1  the 100 MHz system clock, shared with the scanner.
- `rst`  in  1  reset, asynchronous and active-high.
- `hs`  in  1  horizontal sync from the scanner (active-low).
- `vs`  in  1  vertical sync from the scanner (active-low).
- `en`  in  1  visible-area flag from the scanner.
- `x`  in  16  pixel column; 0 when `en`=0.
- `y`  in  16  pixel row; 0 when `en`=0.
- `fb_addr`  out  15  framebuffer read address (registered).
- `fb_data`  in  12  RGB444 read data from the synchronous RAM, valid one cycle after `fb_addr`.
- `cursor_en`  in  1  enables the cursor overlay.
- `cursor_x`  in  8  cursor cell column.
- `cursor_y`  in  7  cursor cell row.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour outputs to the pins.
- `vga_hs`, `vga_vs`  out  1 each  delayed sync outputs to the pins.

## Operation
Stage 1 (edge T+1, computed from inputs sampled at T):
- `cx = x[9:2]`, `cy = y[8:2]`.
- `fb_addr <= cy*160 + cx`, implemented as `(cy<<7) + (cy<<5) + cx` and truncated to 15 bits. The maximum value is 19199.
- When `en`=0, `x`=`y`=0, so `fb_addr` is 0. This is legal; the RAM read result is discarded.
- Pipeline registers take `hs`, `vs`, `en`, and a `hit` flag. `hit` = latched cursor enable AND `cx` equals the latched cursor x AND `cy` equals the latched cursor y.

Stage 2 (edge T+2):
- `rgb = fb_data ^ 12'hFFF` when `hit` and `cursor_on` are both 1; otherwise `rgb = fb_data`.
- When the delayed `en` is 0, `{vga_r, vga_g, vga_b} <= 0`; otherwise they take `rgb`.
- `vga_hs` and `vga_vs` take the stage-1 copies of `hs` and `vs`.

Frame events:
- A register `vs_q` holds the previous `vs`. A frame tick is defined as `vs_q`=1 and `vs`=0 (start of the vertical sync pulse).
- On a frame tick, the cursor inputs `cursor_en`, `cursor_x` and `cursor_y` are latched into the shadow registers used by `hit`. The cursor therefore cannot tear mid-frame.
- On a frame tick, the 8-bit counter `blink_cnt` increments. When it would reach `BLINK_FRAMES`, it wraps to 0 and `cursor_on` toggles.

Boundaries:
- Cursor coordinates with `cursor_x` >= 160 or `cursor_y` >= 120 never match, so no overlay is drawn and there is no error.
- The inputs `x` and `y` are held for 4 clocks per pixel because the scanner advances at 25 MHz. The pipeline registers every clock regardless; no pixel-enable is used.
- `fb_data` is consumed blindly; the block issues no handshake.

## Timing
- Address latency: 1 clock from input to `fb_addr`.
- Pixel latency: 2 clocks from input to the `vga_*` outputs. The sync outputs carry the same 2-clock delay as the colour.
- The shadow registers update at the edge that detects the frame tick. They take effect on the first visible pixel of the next frame; `vs` low implies `en`=0, so no visible pixel is affected mid-frame.
- Reset values, applied asynchronously and immediately on `rst` without waiting for `clk`, including assertion mid-frame:
  - `fb_addr`=0, `vga_r`/`vga_g`/`vga_b`=0, `vga_hs`=1, `vga_vs`=1.
  - The pipeline copies of `hs` and `vs` reset to 1; the pipeline copy of `en` resets to 0.
  - `vs_q`=1, `blink_cnt`=0, `cursor_on`=1, all shadow registers 0.
- After reset is released, the outputs return to tracking the inputs after 2 clocks.

## Test plan
- **Reset mid-frame:** pulse `rst` between clock edges with `vga_r`=4'hA -> all colour outputs are 0 and `vga_hs`/`vga_vs` are 1 before the next clock edge; `blink_cnt` is 0.
- **Address math:** `x`=5, `y`=9, `en`=1 -> `fb_addr`=321 at the next edge. `x`=639, `y`=479 -> 19199.
- **Latency and alignment:** drive `hs`=0 and set `fb_data`=12'hABC one cycle after the address -> `vga_hs`=0 and `{r,g,b}`={A,B,C} at edge T+2. With `en`=0 and `fb_data`=12'hFFF -> colour outputs are 0.
- **Cursor overlay:**
  - Set `cursor_en`=1, `cursor_x`=1, `cursor_y`=2, then apply one `vs` falling edge.
  - Pixels with `x`=4..7 and `y`=8..11 read with `fb_data`=12'h123 -> output 12'hEDC.
  - Pixel `x`=8 -> output 12'h123.
- **Blink:** with `BLINK_FRAMES`=2, apply 2 frame ticks -> `cursor_on`=0 and no inversion. 2 more ticks -> inversion returns. A `vs` held low for many clocks counts as exactly one tick.
- **Out-of-range cursor:** latch `cursor_x`=160 -> no pixel in the frame is ever inverted.
